// File: rtl/pulse_pkg.sv
// Shared types for the pulse train analyzer and its generator-side code.
// Holds the FSM state encoding and the default counter width.
package pulse_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HIGH,
    LOW
  } state_t;

endpackage

// File: rtl/pulse_edge_sync.sv
// Synchronizer chain plus registered edge detector for an async input.
// rise/fall/level are aligned; rise appears SYNC_STAGES+1 cycles after pulse_in.
module pulse_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse_in,
  output logic rise,
  output logic fall,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign level = prev_q;

endmodule

// File: rtl/pulse_train_analyzer.sv
// Measures period and high time of an async pulse train, with timeout.
// Optional PULSE_ANALYZER_MATCH_EN adds a compare against expected values.
module pulse_train_analyzer
  import pulse_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] measured_interval,
  output logic [CNT_W-1:0] measured_width,
  output logic             meas_valid,
  output logic             overflow,
  output logic             timeout
`ifdef PULSE_ANALYZER_MATCH_EN
  ,
  input  logic [CNT_W-1:0] expected_interval,
  input  logic [CNT_W-1:0] expected_width,
  output logic             mismatch
`endif
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt_i;
  logic [CNT_W-1:0] cnt_e;
  logic [CNT_W-1:0] cnt_w;
  logic [CNT_W-1:0] width_q;
  logic             w_sat;
  logic             rise;
  logic             fall;
  logic             level;
  logic             publish;
  logic             gap_hit;

  pulse_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .pulse_in(pulse_in),
    .rise    (rise),
    .fall    (fall),
    .level   (level)
  );

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + ONE;
  endfunction

  assign publish = enable && (state == LOW) && rise;
  // cnt_e counts cycles since the last edge of either polarity
  assign gap_hit = &cnt_e;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      cnt_i             <= '0;
      cnt_e             <= '0;
      cnt_w             <= '0;
      width_q           <= '0;
      w_sat             <= 1'b0;
      measured_interval <= '0;
      measured_width    <= '0;
      meas_valid        <= 1'b0;
      overflow          <= 1'b0;
      timeout           <= 1'b0;
    end else begin
      meas_valid <= publish;
      if (!enable) begin
        state   <= IDLE;
        cnt_i   <= '0;
        cnt_e   <= '0;
        cnt_w   <= '0;
        timeout <= 1'b0;
      end else begin
        unique case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (rise) begin
              state <= HIGH;
              cnt_i <= ONE;
              cnt_e <= ONE;
              cnt_w <= ONE;
            end
          end
          HIGH: begin
            if (fall) begin
              state   <= LOW;
              width_q <= cnt_w;
              w_sat   <= &cnt_w;
              cnt_i   <= sat_inc(cnt_i);
              cnt_e   <= ONE;
            end else if (gap_hit) begin
              state   <= ARM;
              timeout <= 1'b1;
              cnt_i   <= '0;
              cnt_e   <= '0;
              cnt_w   <= '0;
            end else begin
              cnt_i <= sat_inc(cnt_i);
              cnt_e <= sat_inc(cnt_e);
              if (level) cnt_w <= sat_inc(cnt_w);
            end
          end
          LOW: begin
            if (rise) begin
              state             <= HIGH;
              measured_interval <= cnt_i;
              measured_width    <= width_q;
              overflow          <= (&cnt_i) | w_sat;
              cnt_i             <= ONE;
              cnt_e             <= ONE;
              cnt_w             <= ONE;
            end else if (gap_hit) begin
              state   <= ARM;
              timeout <= 1'b1;
              cnt_i   <= '0;
              cnt_e   <= '0;
              cnt_w   <= '0;
            end else begin
              cnt_i <= sat_inc(cnt_i);
              cnt_e <= sat_inc(cnt_e);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PULSE_ANALYZER_MATCH_EN
  logic miss;

  assign miss = (cnt_i != expected_interval) |
                (width_q != expected_width);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mismatch <= 1'b0;
    else if (publish) mismatch <= miss;
  end
`else
  // default build carries no reference compare
`endif

endmodule

// File: tb/tb_pulse_train_analyzer.sv
// Directed bench for pulse_train_analyzer, CNT_W=8, SYNC_STAGES=2.
// Define PULSE_ANALYZER_MATCH_EN to also exercise the compare output.
module tb_pulse_train_analyzer;
  import pulse_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       pulse_in = 1'b0;
  logic [7:0] measured_interval;
  logic [7:0] measured_width;
  logic       meas_valid;
  logic       overflow;
  logic       timeout;
`ifdef PULSE_ANALYZER_MATCH_EN
  logic [7:0] expected_interval = 8'd10;
  logic [7:0] expected_width = 8'd3;
  logic       mismatch;
`endif

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;
  int seen;
  int n;

  pulse_train_analyzer dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .pulse_in         (pulse_in),
    .measured_interval(measured_interval),
    .measured_width   (measured_width),
    .meas_valid       (meas_valid),
    .overflow         (overflow),
    .timeout          (timeout)
`ifdef PULSE_ANALYZER_MATCH_EN
    ,
    .expected_interval(expected_interval),
    .expected_width   (expected_width),
    .mismatch         (mismatch)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drives n periods of a synchronous source; checks strobes past skip.
  task automatic run_train(
    input  int n_p, input int per, input int wid, input int skip,
    input  int exp_i, input int exp_w, input int exp_o,
    output int nstb
  );
    int cnt = 0;
    int last = -1;
    for (int c = 0; c < n_p * per; c++) begin
      step();
      if (meas_valid) begin
        cnt++;
        if (cnt > skip) begin
          chk("interval", 32'(measured_interval), exp_i);
          chk("width", 32'(measured_width), exp_w);
          chk("overflow", 32'(overflow), exp_o);
          if (last >= 0) chk("spacing", cyc - last, per);
        end
        last = cyc;
      end
      pulse_in = ((c % per) < wid);
      if ((c % per) == wid) last_fall = cyc;
    end
    nstb = cnt;
  endtask

  initial begin
    step();
    step();
    chk("rst_interval", 32'(measured_interval), 0);
    chk("rst_width", 32'(measured_width), 0);
    chk("rst_valid", 32'(meas_valid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    #2 reset = 1'b1;
    step();
    step();
    enable = 1'b1;

    run_train(6, 10, 3, 0, 10, 3, 0, n);
    chk("train10_count", n, 5);

    run_train(5, 15, 5, 1, 15, 5, 0, n);
    chk("train15_count", n, 5);

    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (meas_valid) begin
        seen++;
        chk("pre_dis_interval", 32'(measured_interval), 15);
        chk("pre_dis_width", 32'(measured_width), 5);
      end
      if (i == 6) begin
        chk("pre_dis_state", 32'(dut.state), 32'(HIGH));
        enable = 1'b0;
      end
      pulse_in = 1'b1;
    end
    chk("pre_dis_count", seen, 1);

    seen = 0;
    for (int j = 0; j < 40; j++) begin
      step();
      if (meas_valid) seen++;
      pulse_in = ((j % 10) < 3);
    end
    chk("dis_strobes", seen, 0);
    chk("dis_hold_int", 32'(measured_interval), 15);
    chk("dis_hold_wid", 32'(measured_width), 5);
    chk("dis_state", 32'(dut.state), 32'(IDLE));

    enable = 1'b1;
    run_train(3, 10, 3, 0, 10, 3, 0, n);
    chk("reen_count", n, 2);

    seen = 0;
    for (int d = 0; d < 300; d++) begin
      step();
      if (meas_valid) seen++;
      if (cyc == last_fall + 258)
        chk("to_before", 32'(timeout), 0);
      if (cyc == last_fall + 259) begin
        chk("to_set", 32'(timeout), 1);
        chk("to_state", 32'(dut.state), 32'(ARM));
      end
      pulse_in = 1'b0;
    end
    chk("to_strobes", seen, 0);
    chk("to_sticky", 32'(timeout), 1);

    enable = 1'b0;
    step();
    step();
    chk("to_clear", 32'(timeout), 0);
    enable = 1'b1;
    step();

    run_train(3, 300, 200, 0, 255, 200, 1, n);
    chk("sat_count", n, 2);
    chk("sat_hold", 32'(overflow), 1);
    run_train(2, 10, 3, 1, 10, 3, 0, n);
    chk("unsat_count", n, 2);

    run_train(3, 10, 3, 0, 10, 3, 0, n);
    step();
    step();
    chk("pre_rst_state", 32'(dut.state), 32'(LOW));
    #3 reset = 1'b0;
    #1;
    chk("arst_interval", 32'(measured_interval), 0);
    chk("arst_width", 32'(measured_width), 0);
    chk("arst_valid", 32'(meas_valid), 0);
    chk("arst_overflow", 32'(overflow), 0);
    chk("arst_timeout", 32'(timeout), 0);
    chk("arst_state", 32'(dut.state), 32'(IDLE));
    pulse_in = 1'b1;
    step();
    step();
    #2 reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 36; k++) begin
      step();
      if (meas_valid) seen++;
      pulse_in = (k < 16);
    end
    chk("rel_strobes", seen, 0);
    run_train(4, 10, 3, 1, 10, 3, 0, n);

`ifdef PULSE_ANALYZER_MATCH_EN
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (meas_valid) begin
        seen++;
        if (seen > 1) begin
          chk("mm_flag", 32'(mismatch), 1);
          chk("mm_width", 32'(measured_width), 4);
          chk("mm_interval", 32'(measured_interval), 10);
        end
      end
      pulse_in = ((c % 10) < 4);
    end
    chk("mm_count", seen, 5);
    chk("mm_hold", 32'(mismatch), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
